// File: rtl/wb_master_cmd_pkg.sv
// Shared definitions for the Wishbone command initiator.
//   - transfer size encodings carried on cmd_size
//   - FSM state encoding (also exported on the debug port)
//   - default bus timeout
//   - alignment legality helper used when a command is accepted
package wb_master_cmd_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A transfer is legal when its size is defined and the byte offset is a
  // multiple of the transfer width.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~off[0];
      SIZE_WORD: return (off == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane helper.
// Ports:
//   size      : transfer size (byte/half/word)
//   off       : byte offset addr[1:0]
//   wdata     : right-aligned write data
//   rdata     : raw 32-bit bus read data
//   sel       : Wishbone byte lane selects
//   wdata_rep : write data replicated across all lanes of its width
//   rdata_ext : addressed lane shifted down and zero-extended
module wb_lane_align
  import wb_master_cmd_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] rshift;

  // Bring the addressed byte lane down to bit 0.
  assign rshift = rdata >> {off, 3'b000};

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    case (size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'd0, rshift[7:0]};
      end
      SIZE_HALF: begin
        sel       = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'd0, rshift[15:0]};
      end
      SIZE_WORD: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_master_cmd.sv
// Wishbone classic initiator driven by a valid/ready command port.
// One command produces at most one single read/write bus cycle and exactly
// one response (unless reset intervenes).
//
// Handshakes: a command transfers on a clock edge where cmd_valid & cmd_ready;
// a response retires on an edge where rsp_valid & rsp_ready. rsp_valid and its
// payload are held stable until retirement.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_*             : command in (we, size, byte addr, right-aligned data)
//   rsp_*             : response out (data right-aligned/zero-extended, err)
//   wbm_*             : Wishbone classic master signals
//   dbg_state         : current FSM state
module wb_master_cmd
  import wb_master_cmd_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int TO_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [1:0]           cmd_size,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [ADDR_BITS-3:0] wbm_addr_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_data_o,
  output logic                 wbm_we_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i,
  output state_t               dbg_state
);

  state_t             state, state_next;
  logic               lat_we;
  logic [1:0]         lat_size;
  logic [1:0]         lat_off;
  logic [TO_BITS-1:0] to_cnt;

  logic               cmd_legal;
  logic               timeout_hit;
  logic [1:0]         align_size;
  logic [1:0]         align_off;
  logic [3:0]         sel_w;
  logic [31:0]        wdata_w;
  logic [31:0]        rdata_w;

  assign cmd_legal = is_legal(cmd_size, cmd_addr[1:0]);

  // to_cnt holds the number of REQ cycles already completed, so the edge that
  // ends the TIMEOUT-th cycle sees TIMEOUT-1.
  assign timeout_hit = (to_cnt == TO_BITS'(TIMEOUT - 1));

  // Lane helper is shared: in IDLE it shapes the incoming command, afterwards
  // it extracts read data for the latched command.
  assign align_size = (state == ST_IDLE) ? cmd_size       : lat_size;
  assign align_off  = (state == ST_IDLE) ? cmd_addr[1:0]  : lat_off;

  wb_lane_align u_lane_align (
    .size      (align_size),
    .off       (align_off),
    .wdata     (cmd_data),
    .rdata     (wbm_data_i),
    .sel       (sel_w),
    .wdata_rep (wdata_w),
    .rdata_ext (rdata_w)
  );

  // State is IDLE while reset is held, so gate ready with rst explicitly.
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = cmd_legal ? ST_REQ : ST_RESP;
      ST_REQ:  if (wbm_ack_i || timeout_hit) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_size   <= SIZE_BYTE;
      lat_off    <= 2'b00;
      to_cnt     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_err    <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_addr_o <= '0;
      wbm_sel_o  <= 4'b0000;
      wbm_data_o <= 32'd0;
      wbm_we_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lat_we   <= cmd_we;
            lat_size <= cmd_size;
            lat_off  <= cmd_addr[1:0];
            to_cnt   <= '0;
            if (cmd_legal) begin
              wbm_cyc_o  <= 1'b1;
              wbm_stb_o  <= 1'b1;
              wbm_addr_o <= cmd_addr[ADDR_BITS-1:2];
              wbm_sel_o  <= sel_w;
              wbm_data_o <= wdata_w;
              wbm_we_o   <= cmd_we;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
            end
          end
        end
        ST_REQ: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (wbm_ack_i || timeout_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'b0000;
            rsp_valid <= 1'b1;
            to_cnt    <= '0;
            if (wbm_ack_i) begin
              rsp_err  <= 1'b0;
              rsp_data <= lat_we ? 32'd0 : rdata_w;
            end else begin
              rsp_err  <= 1'b1;
              rsp_data <= 32'd0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_cmd.sv
module tb_wb_master_cmd;
  import wb_master_cmd_pkg::*;

  localparam int ADDR_BITS = 32;
  localparam int TIMEOUT   = 16;
  localparam int TO_BITS   = 5;

  logic                 clk;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [1:0]           cmd_size;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [31:0]          cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic [ADDR_BITS-3:0] wbm_addr_o;
  logic [3:0]           wbm_sel_o;
  logic [31:0]          wbm_data_o;
  logic                 wbm_we_o;
  logic [31:0]          wbm_data_i;
  logic                 wbm_ack_i;
  state_t               dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  wb_master_cmd #(
    .ADDR_BITS (ADDR_BITS),
    .TIMEOUT   (TIMEOUT),
    .TO_BITS   (TO_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_size   (cmd_size),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_addr_o (wbm_addr_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_data_o (wbm_data_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_data_i (wbm_data_i),
    .wbm_ack_i  (wbm_ack_i),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One command end to end. d = cycle index (0 = first cyc cycle) in which the
  // slave asserts ack; d >= TIMEOUT means the slave never answers.
  // rdly = cycles rsp_ready is held low before the response is taken.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] data, input int d, input logic [31:0] rdata,
                        input int rdly);
    int          n;
    int          off;
    logic        legal;
    logic        acked;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic [31:0] held;
    int          cyc_cycles;

    // Reference: derive the expected bus and response from the sizing rules.
    off     = int'(addr[1:0]);
    n       = (size == 2'd3) ? 4 : (1 << size);
    legal   = (size != 2'd3) && ((off % n) == 0);
    acked   = (d < TIMEOUT);
    exp_sel = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = data[8*(i % n) +: 8];
    mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    exp_rd  = (rdata >> (8*off)) & mask;
    exp_data = (legal && acked && !we) ? exp_rd : 32'd0;
    exp_q.push_back(exp_data);

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_size  = size;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;

    if (!legal) begin
      check("illegal_no_cyc", wbm_cyc_o, 0);
    end else begin
      cyc_cycles = 0;
      for (int k = 0; k < TIMEOUT + 4; k++) begin
        if (!wbm_cyc_o) break;
        cyc_cycles++;
        if (k == 0) begin
          check("stb", wbm_stb_o, 1);
          check("addr_o", 32'(wbm_addr_o), addr >> 2);
          check("sel", 32'(wbm_sel_o), 32'(exp_sel));
          check("we", wbm_we_o, we);
          if (we) check("data_o", wbm_data_o, exp_wd);
        end
        wbm_ack_i  = (k == d);
        wbm_data_i = (k == d) ? rdata : $urandom;
        @(posedge clk);
        @(negedge clk);
      end
      wbm_ack_i = 1'b0;
      check("cyc_cycles", cyc_cycles, acked ? d + 1 : TIMEOUT);
      check("cyc_low_after", wbm_cyc_o, 0);
    end

    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, !(legal && acked));
    check("rsp_data", rsp_data, exp_q.pop_front());
    held = rsp_data;
    for (int r = 0; r < rdly; r++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, held);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_retired", rsp_valid, 0);
    check("ready_again", cmd_ready, 1);
  endtask

  initial begin
    int sel_d;
    int dly;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_size   = 2'd0;
    cmd_addr   = '0;
    cmd_data   = '0;
    rsp_ready  = 1'b0;
    wbm_data_i = '0;
    wbm_ack_i  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_sel", 32'(wbm_sel_o), 0);
    check("rst_data_o", wbm_data_o, 0);
    rst = 1'b0;

    // Directed cases
    do_txn(1'b1, 2'd2, 32'h04, 32'h1234_5678, 1, 32'h0, 0);
    do_txn(1'b0, 2'd0, 32'h02, 32'h0, 1, 32'hAABB_CCDD, 0);
    do_txn(1'b1, 2'd1, 32'h06, 32'h0000_BEEF, 1, 32'h0, 0);
    do_txn(1'b0, 2'd1, 32'h03, 32'h0, 1, 32'h1111_2222, 0);
    do_txn(1'b1, 2'd3, 32'h00, 32'hDEAD_BEEF, 1, 32'h0, 0);
    do_txn(1'b0, 2'd2, 32'h10, 32'h0, TIMEOUT, 32'h5555_6666, 0);
    do_txn(1'b0, 2'd2, 32'h14, 32'h0, TIMEOUT - 1, 32'h7777_8888, 0);
    do_txn(1'b0, 2'd1, 32'h22, 32'h0, 2, 32'hCAFE_F00D, 5);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      sel_d = $urandom_range(0, 9);
      if (sel_d < 7)       dly = sel_d % 4;
      else if (sel_d == 7) dly = TIMEOUT - 1;
      else                 dly = TIMEOUT;
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             dly, $urandom, $urandom_range(0, 3));
    end

    // Reset while a bus cycle is outstanding
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_size  = SIZE_WORD;
    cmd_addr  = 32'h40;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_cyc", wbm_cyc_o, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cyc", wbm_cyc_o, 0);
    check("midrst_stb", wbm_stb_o, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_rsp_valid", rsp_valid, 0);
    check("postrst_cyc", wbm_cyc_o, 0);
    check("postrst_cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
